// File: rtl/bm_match_pkg.sv
// Shared constants and types for the bm_match accumulate stage.
package bm_match_pkg;

  localparam int BM_IN_W        = 36;
  localparam int BM_ACC_W       = 44;
  localparam int BM_OUT_W       = 36;
  localparam int BM_NUM_SAMPLES = 16;

  localparam logic [BM_OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/bm_match_out_reg.sv
// Result holding register: loads on the block-complete pulse, drops valid on consume or clear.
module bm_match_out_reg #(
  parameter int W = 36
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] load_data,
  input  logic         load_overflow,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overflow
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         overflow_reg;

  // Data and overflow are retained after a drop; only the valid flag falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (load) begin
      valid_reg    <= 1'b1;
      data_reg     <= load_data;
      overflow_reg <= load_overflow;
    end else if (drop) begin
      valid_reg    <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign data     = data_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/bm_match_accum_stage.sv
// Accumulates NUM_SAMPLES words per block and presents the sum on a valid/ready port.
// Define BM_MATCH_ACCUM_SAT_EN to saturate out_data on overflow instead of truncating.
module bm_match_accum_stage
  import bm_match_pkg::*;
#(
  parameter int IN_W        = BM_IN_W,
  parameter int ACC_W       = BM_ACC_W,
  parameter int OUT_W       = BM_OUT_W,
  parameter int NUM_SAMPLES = BM_NUM_SAMPLES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [OUT_W-1:0] OUT_MAX =
    (OUT_W == BM_OUT_W) ? OUT_W'(SAT_MAX) : {OUT_W{1'b1}};

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             in_ready_reg;

  logic             in_xfer;
  logic             last_xfer;
  logic             out_accept;
  logic [ACC_W-1:0] sum_next;
  logic             sum_ovf;
  logic [OUT_W-1:0] res_next;

  assign in_xfer    = in_valid && in_ready_reg && !clear && (state_reg == ACCUM);
  assign last_xfer  = in_xfer && (count_reg == LAST_CNT);
  assign out_accept = out_valid && out_ready;
  assign sum_next   = acc_reg + ACC_W'(in_data);
  assign sum_ovf    = sum_next > ACC_W'(OUT_MAX);

`ifdef BM_MATCH_ACCUM_SAT_EN
  assign res_next = sum_ovf ? OUT_MAX : sum_next[OUT_W-1:0];
`else
  assign res_next = sum_next[OUT_W-1:0];
`endif

  // in_ready is registered: it tracks the state the FSM will be in next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else if (clear) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ACCUM: begin
          in_ready_reg <= !last_xfer;
          if (last_xfer) begin
            state_reg <= HOLD;
            acc_reg   <= '0;
            count_reg <= '0;
          end else if (in_xfer) begin
            acc_reg   <= sum_next;
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_accept) begin
            state_reg    <= ACCUM;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ACCUM;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_reg;

  bm_match_out_reg #(
    .W(OUT_W)
  ) u_out_reg (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (last_xfer),
    .drop         (clear || out_accept),
    .load_data    (res_next),
    .load_overflow(sum_ovf),
    .valid        (out_valid),
    .data         (out_data),
    .overflow     (out_overflow)
  );

endmodule

// File: tb/tb_bm_match_accum_stage.sv
// Directed bench for bm_match_accum_stage; expected values are hand-computed block sums.
module tb_bm_match_accum_stage;

  logic        clock;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_data;
  logic        out_overflow;

  int n_checks;
  int n_fail;

  bm_match_accum_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_overflow(out_overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a word and wait (bounded) until it is transferred.
  task automatic send(input logic [35:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    step();
  endtask

  task automatic send_block(input logic [35:0] d);
    for (int i = 0; i < 16; i++) send(d);
    in_valid = 1'b0;
  endtask

  logic [35:0] exp_big;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // 1: reset state, then a block of 1s
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_overflow", 64'(out_overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    #10 reset_n = 1'b1;
    step();
    check("t1_in_ready_after_rst", 64'(in_ready), 64'd1);
    send_block(36'd1);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_data", 64'(out_data), 64'd16);
    check("t1_overflow", 64'(out_overflow), 64'd0);
    check("t1_in_ready_hold", 64'(in_ready), 64'd0);
    step();
    check("t1_valid_one_cycle", 64'(out_valid), 64'd0);
    check("t1_in_ready_back", 64'(in_ready), 64'd1);

    // 2: all-ones words overflow the 36-bit result
`ifdef BM_MATCH_ACCUM_SAT_EN
    exp_big = 36'hFFFFFFFFF;
`else
    exp_big = 36'hFFFFFFFF0;
`endif
    send_block(36'hFFFFFFFFF);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_out_data", 64'(out_data), 64'(exp_big));
    check("t2_overflow", 64'(out_overflow), 64'd1);
    step();

    // 3: backpressure with words offered while holding
    out_ready = 1'b0;
    send_block(36'd3);
    in_valid = 1'b1;
    in_data  = 36'd7;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_data", 64'(out_data), 64'd48);
      check("t3_hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t3_accepted", 64'(out_valid), 64'd0);
    check("t3_in_ready_after", 64'(in_ready), 64'd1);
    send_block(36'd1);
    check("t3_next_block", 64'(out_data), 64'd16);
    check("t3_overflow_clr", 64'(out_overflow), 64'd0);
    step();

    // 4: clear drops the partial block and the coincident word
    for (int i = 0; i < 7; i++) send(36'd10);
    in_valid = 1'b1;
    in_data  = 36'd10;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    check("t4_no_result", 64'(out_valid), 64'd0);
    send_block(36'd1);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_out_data", 64'(out_data), 64'd16);
    step();

    // 4b: clear in HOLD drops valid but keeps the held value
    out_ready = 1'b0;
    send_block(36'd2);
    check("t4b_hold", 64'(out_data), 64'd32);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4b_valid_dropped", 64'(out_valid), 64'd0);
    check("t4b_data_kept", 64'(out_data), 64'd32);
    check("t4b_in_ready", 64'(in_ready), 64'd1);

    // 5: asynchronous reset mid-block and in HOLD
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(36'd4);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_mid_in_ready", 64'(in_ready), 64'd0);
    check("t5_mid_data", 64'(out_data), 64'd0);
    reset_n = 1'b1;
    step();
    out_ready = 1'b0;
    send_block(36'd2);
    check("t5_fresh_block", 64'(out_data), 64'd32);
    check("t5_hold_valid", 64'(out_valid), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check("t5_hold_rst_valid", 64'(out_valid), 64'd0);
    check("t5_hold_rst_data", 64'(out_data), 64'd0);
    check("t5_hold_rst_ovf", 64'(out_overflow), 64'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    send_block(36'd5);
    check("t5_out_data", 64'(out_data), 64'd80);
    check("t5_out_valid", 64'(out_valid), 64'd1);
    step();

    // 6: in_valid every other cycle, data 0..15
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 36'(i);
      check("t6_in_ready", 64'(in_ready), 64'd1);
      step();
      if (i == 15) begin
        check("t6_out_valid", 64'(out_valid), 64'd1);
        check("t6_out_data", 64'(out_data), 64'd120);
      end else begin
        check("t6_no_early_result", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b0;
      step();
    end
    check("t6_consumed", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bm_match_accum_stage.md
Name: bm_match_accum_stage

Overview:
- Downstream consumer of the 36-bit sum-of-products produced by the bm_match multiply-add stage.
- Accepts one unsigned word per valid/ready handshake and accumulates NUM_SAMPLES words into a wide accumulator.
- Presents the block result on a valid/ready output port and holds it until the consumer accepts it.
- Exercises counter, small FSM and handshake inference in the synthesis flow.

Parameters:
- IN_W, 36, input word width (unsigned)
- ACC_W, 44, accumulator width; must be >= IN_W + clog2(NUM_SAMPLES)
- OUT_W, 36, result width
- NUM_SAMPLES, 16, words per accumulation block; must be >= 2

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: discard the partial block and return to ACCUM with acc = 0, count = 0
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_W  word to accumulate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  block result
- out_overflow  out  1  result exceeded 2^OUT_W-1 (sticky per block)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = ACCUM; acc = 0; count = 0.
  - Outputs: out_valid = 0, out_data = 0, out_overflow = 0, in_ready = 0.
  - in_ready rises one cycle after reset_n deasserts; it is a registered start flag.
- Input transfer occurs when in_valid && in_ready on a rising clock edge.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready = 1.
  - Each transfer: acc <= acc + zero-extended in_data (ACC_W bits, unsigned wrap); count <= count + 1.
  - On the transfer with count == NUM_SAMPLES-1:
    - Go to HOLD.
    - out_data and out_overflow are registered from acc + in_data.
    - out_valid = 1 on the next cycle, giving one cycle of latency from the last accepted word.
    - acc and count reset to 0.
  - The count register wraps to 0 only at the block boundary.
- HOLD:
  - in_ready = 0.
  - out_data and out_valid stay stable until the cycle where out_valid && out_ready.
  - After acceptance: out_valid = 0 and the FSM returns to ACCUM.
  - in_ready = 1 in the cycle after acceptance; there is no same-cycle bypass.
- Result width:
  - Full sum S is ACC_W bits.
  - If S > 2^OUT_W-1, out_overflow = 1.
  - out_data per the Optional Feature below.
- clear:
  - Has priority over an input transfer in the same cycle; that word is dropped.
  - In HOLD, clear also drops the pending result: out_valid = 0 on the next cycle.
  - clear does not affect out_data's held value other than the valid flag.
- reset_n asserted mid-block: all state is lost immediately and the partial sum is discarded.
- out_ready while out_valid = 0 has no effect.
- in_valid while in_ready = 0 has no effect; the producer must hold the word.

Optional Feature:
- Macro: BM_MATCH_ACCUM_SAT_EN.
- Defined: on overflow, out_data = 2^OUT_W-1 (saturate).
- Undefined: out_data = S[OUT_W-1:0] (truncate/wrap).
- out_overflow behaves the same in both builds.

Decomposition:
- Shared package bm_match_pkg holds:
  - Width constants IN_W, ACC_W, OUT_W and NUM_SAMPLES defaults.
  - State enum {ACCUM, HOLD}.
  - SAT_MAX constant (2^OUT_W-1).
- One natural sub-module: bm_match_out_reg.
  - Output holding register with valid/ready.
  - Loads on accept-pulse and clears on consume or clear.
- Counter and accumulator stay in the top module.

Test Plan:
1. Reset then 16 words of value 1, in_valid held high, out_ready = 1 -> in_ready high from cycle 1; out_valid for exactly 1 cycle with out_data = 16 one cycle after the 16th transfer; out_overflow = 0.
2. 16 words of 2^36-1 -> S = 16*(2^36-1); out_overflow = 1. With SAT_EN: out_data = 0xFFFFFFFFF. Without: out_data = S[35:0] = 0xFFFFFFFF0.
3. Backpressure: complete a block of 3s (expected 48) with out_ready = 0 for 5 cycles -> out_data = 48 stable, in_ready = 0 and incoming words ignored; raise out_ready -> one transfer, then in_ready = 1 the next cycle and the next block starts from 0.
4. clear after 7 words of 10, asserted in the same cycle as an 8th valid word -> that word is dropped; the next 16 words of 1 give out_data = 16.
5. Assert reset_n low asynchronously mid-block after 9 words, and again while in HOLD -> out_valid and out_data fall to 0 immediately without waiting for a clock edge; after release, a fresh 16-word block of 5 gives 80.
6. in_valid toggling every other cycle with data 0..15 -> out_data = 120; count advances only on transfers.
